step_ctrl: RTL and testbench

Execution sequencer for the pipelined CPU. It debounces the front-panel button and produces a single-cycle clock-enable (cpu_ce) for the CPU and data memory. Supports single-step, free-run at a divided rate, and a PC breakpoint on i_addr. It also exports a step counter and state for the seven-segment display path.

---
 rtl/step_ctrl.sv | 142 ++++++++++++++
 tb/tb_step_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// Execution sequencer: debounces the front-panel button and issues single-cycle
// CPU clock enables for single-step, divided free-run and PC-breakpoint stops.
module step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000,
  parameter int unsigned RUN_DIV         = 1000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic             run_mode,
  input  logic             bp_enable,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       i_addr,
  input  logic             halt_in,
  output logic             cpu_ce,
  output logic             bp_hit,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2,
    BREAK = 2'd3
  } state_t;

  logic            sync1;
  logic            btn_s;
  logic            db;
  logic            db_d;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             resume_q, resume_d;
  logic             ce_d;
  logic             tick;
  logic             bp_match;

  // Synchronizer and debounce: db only follows btn_s after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      btn_s  <= 1'b0;
      db     <= 1'b0;
      db_d   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= button;
      btn_s <= sync1;
      db_d  <= db;
      if (btn_s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db     <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign press    = db & ~db_d;
  assign tick     = (div_q == DIV_W'(RUN_DIV - 1));
  assign bp_match = bp_enable && (i_addr == bp_addr);

  // Next-state logic; ce_d becomes the registered cpu_ce for the following cycle.
  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    resume_d = resume_q;
    ce_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press && !halt_in) begin
          resume_d = 1'b0;
          if (run_mode) begin
            state_d = RUN;
          end else begin
            state_d = STEP;
            ce_d    = 1'b1;
          end
        end
      end
      STEP: begin
        resume_d = 1'b0;
        state_d  = resume_q ? RUN : IDLE;
      end
      RUN: begin
        if (halt_in || press) begin
          state_d = IDLE;
        end else if (tick) begin
          if (bp_match) begin
            state_d = BREAK;
          end else begin
            ce_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      BREAK: begin
        if (halt_in) begin
          state_d = IDLE;
        end else if (press) begin
          state_d  = STEP;
          ce_d     = 1'b1;
          resume_d = run_mode;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      resume_q   <= 1'b0;
      cpu_ce     <= 1'b0;
      bp_hit     <= 1'b0;
      step_count <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      resume_q   <= resume_d;
      cpu_ce     <= ce_d;
      bp_hit     <= (state_d == BREAK);
      step_count <= step_count + CNT_W'(ce_d);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=3, CNT_W=4.
module tb_step_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             button;
  logic             run_mode;
  logic             bp_enable;
  logic [7:0]       bp_addr;
  logic [7:0]       i_addr;
  logic             halt_in;
  logic             cpu_ce;
  logic             bp_hit;
  logic [1:0]       state;
  logic [CNT_W-1:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;

  step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (3),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .run_mode  (run_mode),
    .bp_enable (bp_enable),
    .bp_addr   (bp_addr),
    .i_addr    (i_addr),
    .halt_in   (halt_in),
    .cpu_ce    (cpu_ce),
    .bp_hit    (bp_hit),
    .state     (state),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns in the cycle where the internal press pulse is high.
  task automatic press_btn(input logic rm);
    run_mode = rm;
    button   = 1'b1;
    cyc(6);
    button   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_ce"}, 32'(cpu_ce), 32'd0);
    check({tag, "_bp_hit"}, 32'(bp_hit), 32'd0);
    check({tag, "_count"}, 32'(step_count), 32'd0);
  endtask

  initial begin
    int ce_seen;
    int bad;
    reset     = 1'b1;
    button    = 1'b0;
    run_mode  = 1'b0;
    bp_enable = 1'b0;
    bp_addr   = 8'h00;
    i_addr    = 8'h00;
    halt_in   = 1'b0;

    // Reset state and single step
    do_reset();
    check_zero("reset");
    press_btn(1'b0);
    check("pre_step_ce", 32'(cpu_ce), 32'd0);
    check("pre_step_state", 32'(state), 32'd0);
    cyc(1);
    check("step_ce", 32'(cpu_ce), 32'd1);
    check("step_state", 32'(state), 32'd1);
    check("step_count1", 32'(step_count), 32'd1);
    cyc(1);
    check("after_step_state", 32'(state), 32'd0);
    check("after_step_ce", 32'(cpu_ce), 32'd0);
    ce_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (cpu_ce) ce_seen++;
    end
    check("step_single_pulse", 32'(ce_seen), 32'd0);
    check("step_count_hold", 32'(step_count), 32'd1);

    // Glitch shorter than the debounce window
    button = 1'b1;
    cyc(3);
    button = 1'b0;
    ce_seen = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (cpu_ce) ce_seen++;
      if (state != 2'd0) bad++;
    end
    check("glitch_ce", 32'(ce_seen), 32'd0);
    check("glitch_state", 32'(bad), 32'd0);

    // Free run, counter wrap, stop by press on a tick cycle
    do_reset();
    press_btn(1'b1);
    cyc(1);
    check("run_enter_state", 32'(state), 32'd2);
    check("run_enter_ce", 32'(cpu_ce), 32'd0);
    ce_seen = 0;
    bad = 0;
    for (int i = 2; i <= 49; i++) begin
      cyc(1);
      if (cpu_ce) ce_seen++;
      if (cpu_ce !== ((i >= 4) && ((i - 4) % 3 == 0))) bad++;
    end
    check("run_ce_pattern", 32'(bad), 32'd0);
    check("run_pulses", 32'(ce_seen), 32'd16);
    check("run_count_wrap", 32'(step_count), 32'd0);
    cyc(2);
    press_btn(1'b1);
    cyc(1);
    check("stop_ce", 32'(cpu_ce), 32'd0);
    check("stop_state", 32'(state), 32'd0);
    check("stop_count", 32'(step_count), 32'd2);
    ce_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (cpu_ce) ce_seen++;
    end
    check("stopped_ce", 32'(ce_seen), 32'd0);

    // Breakpoint, step-over, resume
    do_reset();
    bp_enable = 1'b1;
    bp_addr   = 8'h05;
    i_addr    = 8'h03;
    press_btn(1'b1);
    cyc(4);
    check("bp_run_ce", 32'(cpu_ce), 32'd1);
    i_addr = 8'h05;
    cyc(3);
    check("bp_state", 32'(state), 32'd3);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_ce", 32'(cpu_ce), 32'd0);
    check("bp_count", 32'(step_count), 32'd1);
    cyc(8);
    check("bp_hold_state", 32'(state), 32'd3);
    press_btn(1'b1);
    check("bp_press_hit", 32'(bp_hit), 32'd1);
    cyc(1);
    check("bp_step_state", 32'(state), 32'd1);
    check("bp_step_ce", 32'(cpu_ce), 32'd1);
    check("bp_step_hit", 32'(bp_hit), 32'd0);
    check("bp_step_count", 32'(step_count), 32'd2);
    i_addr = 8'h06;
    cyc(1);
    check("resume_state", 32'(state), 32'd2);
    check("resume_ce0", 32'(cpu_ce), 32'd0);
    cyc(3);
    check("resume_ce", 32'(cpu_ce), 32'd1);
    check("resume_count", 32'(step_count), 32'd3);

    // Halt during run, press while halted
    halt_in = 1'b1;
    cyc(1);
    check("halt_state", 32'(state), 32'd0);
    check("halt_ce", 32'(cpu_ce), 32'd0);
    ce_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (cpu_ce) ce_seen++;
    end
    check("halt_no_ce", 32'(ce_seen), 32'd0);
    press_btn(1'b0);
    cyc(1);
    check("halt_press_state", 32'(state), 32'd0);
    check("halt_press_ce", 32'(cpu_ce), 32'd0);
    halt_in = 1'b0;
    cyc(8);

    // Reset during STEP
    press_btn(1'b0);
    cyc(1);
    check("pre_rst_step_state", 32'(state), 32'd1);
    reset = 1'b1;
    cyc(1);
    check_zero("rst_step");
    reset = 1'b0;
    cyc(1);
    check("rst_step_next_ce", 32'(cpu_ce), 32'd0);
    check("rst_step_next_state", 32'(state), 32'd0);

    // Reset during RUN on a tick cycle
    cyc(4);
    press_btn(1'b1);
    cyc(4);
    check("pre_rst_run_ce", 32'(cpu_ce), 32'd1);
    check("pre_rst_run_count", 32'(step_count), 32'd1);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check_zero("rst_run");
    reset = 1'b0;
    ce_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (cpu_ce) ce_seen++;
    end
    check("rst_run_after_ce", 32'(ce_seen), 32'd0);
    check("rst_run_after_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
